// File: rtl/uninasoc_pkg.sv
// Shared SoC definitions: interrupt controller register offsets, source modes
// and the platform interrupt-source count.
package uninasoc_pkg;

  localparam int NUM_IRQ = 3;

  localparam logic [4:0] IRQ_PENDING_OFF   = 5'h00;
  localparam logic [4:0] IRQ_ENABLE_OFF    = 5'h04;
  localparam logic [4:0] IRQ_MODE_OFF      = 5'h08;
  localparam logic [4:0] IRQ_CLAIM_OFF     = 5'h0C;
  localparam logic [4:0] IRQ_INSERVICE_OFF = 5'h10;

  typedef enum logic {IRQ_LEVEL, IRQ_EDGE} irq_mode_e;

  // Register decode works on word addresses; byte-lane bits are ignored.
  function automatic logic [4:0] irq_word_addr(input logic [4:0] addr);
    return {addr[4:2], 2'b00};
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational lowest-index-first priority encoder over an N-bit request vector.
module irq_prio_enc #(
  parameter int N     = 3,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);
  import uninasoc_pkg::*;

  // Scan from the top down so the lowest set bit is the last one assigned.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        valid_o = 1'b1;
        idx_o   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/soc_irq_ctrl.sv
// Platform interrupt controller: per-source enable, level/edge mode, pending and
// in-service tracking, fixed-priority claim/complete. Optional macro IRQ_SYNC_EN.
module soc_irq_ctrl #(
  parameter int NUM_IRQ = uninasoc_pkg::NUM_IRQ,
  parameter int ID_W    = $clog2(NUM_IRQ + 1)
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  output logic               irq_o,
  input  logic               reg_req_i,
  input  logic               reg_we_i,
  input  logic [4:0]         reg_addr_i,
  input  logic [31:0]        reg_wdata_i,
  output logic [31:0]        reg_rdata_o,
  output logic               reg_ack_o
);
  import uninasoc_pkg::*;

  localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  logic [NUM_IRQ-1:0] r_pend;
  logic [NUM_IRQ-1:0] r_en;
  logic [NUM_IRQ-1:0] r_mode;
  logic [NUM_IRQ-1:0] r_insvc;
  logic [NUM_IRQ-1:0] r_hist;
  logic               r_irq;
  logic               r_ack;
  logic [31:0]        r_rdata;

  logic [NUM_IRQ-1:0] w_irq_s;
  logic [NUM_IRQ-1:0] w_edge;
  logic [NUM_IRQ-1:0] w_elig;
  logic [NUM_IRQ-1:0] w_rise;
  logic [NUM_IRQ-1:0] w_wdata_m;
  logic [NUM_IRQ-1:0] w_w1c;
  logic [NUM_IRQ-1:0] w_claim_vec;
  logic [NUM_IRQ-1:0] w_cmpl_vec;
  logic [NUM_IRQ-1:0] w_pend_nxt;
  logic [NUM_IRQ-1:0] w_insvc_nxt;
  logic [4:0]         w_word;
  logic               w_rd;
  logic               w_wr;
  logic               w_sel_pend;
  logic               w_sel_en;
  logic               w_sel_mode;
  logic               w_sel_claim;
  logic               w_valid;
  logic [IDX_W-1:0]   w_idx;
  logic [ID_W-1:0]    w_id;
  logic               w_claim;
  logic               w_cmpl_ok;
  logic [31:0]        w_rd_data;
  logic               w_unused;

`ifdef IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] r_sync1;
  logic [NUM_IRQ-1:0] r_sync2;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= irq_i;
      r_sync2 <= r_sync1;
    end
  end

  assign w_irq_s = r_sync2;
`else
  assign w_irq_s = irq_i;
`endif

  assign w_unused    = ^{reg_addr_i[1:0], reg_wdata_i};
  assign w_word      = irq_word_addr(reg_addr_i);
  assign w_rd        = reg_req_i & ~reg_we_i;
  assign w_wr        = reg_req_i & reg_we_i;
  assign w_sel_pend  = (w_word == IRQ_PENDING_OFF);
  assign w_sel_en    = (w_word == IRQ_ENABLE_OFF);
  assign w_sel_mode  = (w_word == IRQ_MODE_OFF);
  assign w_sel_claim = (w_word == IRQ_CLAIM_OFF);
  assign w_wdata_m   = reg_wdata_i[NUM_IRQ-1:0];

  always_comb begin
    w_edge = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      w_edge[i] = (irq_mode_e'(r_mode[i]) == IRQ_EDGE);
    end
  end

  assign w_elig = r_pend & r_en & ~r_insvc;

  irq_prio_enc #(
    .N     (NUM_IRQ),
    .IDX_W (IDX_W)
  ) u_prio (
    .req_i   (w_elig),
    .valid_o (w_valid),
    .idx_o   (w_idx)
  );

  assign w_id        = w_valid ? (ID_W'(w_idx) + ID_W'(1)) : '0;
  assign w_claim     = w_rd & w_sel_claim & w_valid;
  assign w_claim_vec = w_claim ? (NUM_IRQ'(1) << w_idx) : '0;
  assign w_cmpl_ok   = w_wr & w_sel_claim & (reg_wdata_i != 32'd0) &
                       (reg_wdata_i <= 32'(NUM_IRQ));
  assign w_cmpl_vec  = w_cmpl_ok ? (NUM_IRQ'(1) << (reg_wdata_i - 32'd1)) : '0;
  assign w_w1c       = (w_wr & w_sel_pend) ? (w_wdata_m & w_edge) : '0;
  assign w_rise      = w_irq_s & ~r_hist;

  // Edge sources: a new rise beats any clear in the same cycle.
  // Level sources simply mirror the sampled line.
  assign w_pend_nxt  = (w_edge & (w_rise | (r_pend & ~(w_w1c | w_claim_vec)))) |
                       (~w_edge & w_irq_s);
  assign w_insvc_nxt = (r_insvc | w_claim_vec) & ~w_cmpl_vec;

  always_comb begin
    w_rd_data = 32'd0;
    case (w_word)
      IRQ_PENDING_OFF:   w_rd_data = 32'(r_pend);
      IRQ_ENABLE_OFF:    w_rd_data = 32'(r_en);
      IRQ_MODE_OFF:      w_rd_data = 32'(r_mode);
      IRQ_CLAIM_OFF:     w_rd_data = 32'(w_id);
      IRQ_INSERVICE_OFF: w_rd_data = 32'(r_insvc);
      default:           w_rd_data = 32'd0;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_pend  <= '0;
      r_en    <= '0;
      r_mode  <= '0;
      r_insvc <= '0;
      r_hist  <= '0;
      r_irq   <= 1'b0;
      r_ack   <= 1'b0;
      r_rdata <= 32'd0;
    end else begin
      r_hist  <= w_irq_s;
      r_pend  <= w_pend_nxt;
      r_insvc <= w_insvc_nxt;
      if (w_wr && w_sel_en) begin
        r_en <= w_wdata_m;
      end
      if (w_wr && w_sel_mode) begin
        r_mode <= w_wdata_m;
      end
      r_irq   <= |w_elig;
      r_ack   <= reg_req_i;
      r_rdata <= w_rd ? w_rd_data : 32'd0;
    end
  end

  assign irq_o       = r_irq;
  assign reg_ack_o   = r_ack;
  assign reg_rdata_o = r_rdata;

endmodule

// File: tb/tb_soc_irq_ctrl.sv
// Self-checking bench for soc_irq_ctrl: directed scenarios plus randomized
// traffic compared every cycle against a per-source behavioural model.
module tb_soc_irq_ctrl;

  localparam int N = 3;
`ifdef IRQ_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] irq_r;
  logic         irq_o;
  logic         req;
  logic         we;
  logic [4:0]   addr;
  logic [31:0]  wdata;
  logic [31:0]  rdata;
  logic         ack;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: one entry per source.
  bit          m_pend  [N];
  bit          m_en    [N];
  bit          m_edge  [N];
  bit          m_insvc [N];
  bit          m_prev  [N];
  bit          m_s1    [N];
  bit          m_s2    [N];
  bit          m_irq;
  bit          m_ack;
  logic [31:0] m_rdata;

  always #5 clk = ~clk;

  soc_irq_ctrl #(.NUM_IRQ(N)) dut (
    .clock_i     (clk),
    .reset_i     (rst),
    .irq_i       (irq_r),
    .irq_o       (irq_o),
    .reg_req_i   (req),
    .reg_we_i    (we),
    .reg_addr_i  (addr),
    .reg_wdata_i (wdata),
    .reg_rdata_o (rdata),
    .reg_ack_o   (ack)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pack(input bit v [N]);
    logic [31:0] r = 32'd0;
    for (int i = 0; i < N; i++) r[i] = v[i];
    return r;
  endfunction

  task automatic model_step();
    bit          s [N];
    bit          any = 0;
    int          claimed = -1;
    int          completed = -1;
    logic [31:0] rd = 32'd0;
    logic [31:0] w1c = 32'd0;
    int          word = int'(addr) / 4;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_pend[i] = 0; m_en[i] = 0; m_edge[i] = 0; m_insvc[i] = 0;
        m_prev[i] = 0; m_s1[i] = 0; m_s2[i] = 0;
      end
      m_irq = 0; m_ack = 0; m_rdata = 0;
      return;
    end
    for (int i = 0; i < N; i++) begin
`ifdef IRQ_SYNC_EN
      s[i] = m_s2[i]; m_s2[i] = m_s1[i]; m_s1[i] = irq_r[i];
`else
      s[i] = irq_r[i];
`endif
      if (m_pend[i] && m_en[i] && !m_insvc[i]) any = 1;
    end
    if (req && !we) begin
      case (word)
        0: rd = pack(m_pend);
        1: rd = pack(m_en);
        2: rd = pack(m_edge);
        3: for (int i = 0; i < N; i++)
             if (claimed < 0 && m_pend[i] && m_en[i] && !m_insvc[i]) begin
               claimed = i; rd = i + 1;
             end
        4: rd = pack(m_insvc);
        default: rd = 0;
      endcase
    end
    if (req && we && word == 0) w1c = wdata;
    if (req && we && word == 3 && wdata >= 1 && wdata <= N) completed = int'(wdata) - 1;
    for (int i = 0; i < N; i++) begin
      if (m_edge[i])
        m_pend[i] = (s[i] && !m_prev[i]) || (m_pend[i] && !(w1c[i] || claimed == i));
      else
        m_pend[i] = s[i];
      if (claimed == i) m_insvc[i] = 1;
      if (completed == i) m_insvc[i] = 0;
      m_prev[i] = s[i];
    end
    if (req && we && word == 1) for (int i = 0; i < N; i++) m_en[i] = wdata[i];
    if (req && we && word == 2) for (int i = 0; i < N; i++) m_edge[i] = wdata[i];
    m_irq = any; m_ack = req; m_rdata = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("irq_o", 32'(irq_o), 32'(m_irq));
    check("ack", 32'(ack), 32'(m_ack));
    check("rdata", rdata, m_rdata);
  endtask

  task automatic bus(input bit w, input logic [4:0] a, input logic [31:0] d,
                     output logic [31:0] rd);
    req = 1'b1; we = w; addr = a; wdata = d;
    tick();
    rd = rdata;
    req = 1'b0; we = 1'b0; addr = 5'd0; wdata = 32'd0;
  endtask

  logic [31:0] v;

  initial begin
    rst = 1'b1; irq_r = '0; req = 1'b0; we = 1'b0; addr = 5'd0; wdata = 32'd0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state of every register
    for (int k = 0; k < 5; k++) begin
      bus(1'b0, 5'(k * 4), 32'd0, v);
      check($sformatf("reset_reg%0d", k), v, 32'd0);
    end
    check("reset_irq_o", 32'(irq_o), 32'd0);

    // Level source 0
    bus(1'b1, 5'h04, 32'h1, v);
    bus(1'b1, 5'h08, 32'h0, v);
    irq_r = 3'b001;
    repeat (LAT - 1) tick();
    check("lvl_irq_early", 32'(irq_o), 32'd0);
    tick();
    check("lvl_irq_on", 32'(irq_o), 32'd1);
    bus(1'b0, 5'h0C, 32'd0, v);
    check("lvl_claim", v, 32'd1);
    tick();
    check("lvl_masked", 32'(irq_o), 32'd0);
    bus(1'b1, 5'h0C, 32'd1, v);
    tick();
    check("lvl_reassert", 32'(irq_o), 32'd1);
    irq_r = 3'b000;
    repeat (LAT) tick();
    check("lvl_drop", 32'(irq_o), 32'd0);

    // Edge source 2
    bus(1'b1, 5'h04, 32'h4, v);
    bus(1'b1, 5'h08, 32'h4, v);
    irq_r = 3'b100; tick(); irq_r = 3'b000;
    repeat (LAT - 1) tick();
    bus(1'b0, 5'h00, 32'd0, v);
    check("edge_pend", v, 32'h4);
    bus(1'b0, 5'h0C, 32'd0, v);
    check("edge_claim", v, 32'd3);
    bus(1'b0, 5'h00, 32'd0, v);
    check("edge_pend_clr", v, 32'h0);
    irq_r = 3'b100; tick(); irq_r = 3'b000;
    repeat (LAT) tick();
    bus(1'b0, 5'h00, 32'd0, v);
    check("edge_pend_insvc", v, 32'h4);
    check("edge_irq_masked", 32'(irq_o), 32'd0);
    bus(1'b1, 5'h0C, 32'd3, v);
    tick();
    check("edge_redeliver", 32'(irq_o), 32'd1);
    bus(1'b0, 5'h0C, 32'd0, v);
    bus(1'b1, 5'h0C, 32'd3, v);

    // Priority between sources 0 and 2
    bus(1'b1, 5'h04, 32'h5, v);
    bus(1'b1, 5'h08, 32'h5, v);
    irq_r = 3'b101; tick(); irq_r = 3'b000;
    repeat (LAT - 1) tick();
    bus(1'b0, 5'h0C, 32'd0, v);
    check("prio_1", v, 32'd1);
    bus(1'b0, 5'h0C, 32'd0, v);
    check("prio_3", v, 32'd3);
    bus(1'b0, 5'h0C, 32'd0, v);
    check("prio_none", v, 32'd0);
    bus(1'b1, 5'h0C, 32'd1, v);
    bus(1'b1, 5'h0C, 32'd3, v);

    // W1C colliding with a fresh edge: the edge wins
    irq_r = 3'b100;
    repeat (LAT - 2) tick();
    bus(1'b1, 5'h00, 32'h4, v);
    irq_r = 3'b000;
    bus(1'b0, 5'h00, 32'd0, v);
    check("w1c_vs_edge", v, 32'h4);

    // Out-of-range completes leave in-service alone
    bus(1'b0, 5'h0C, 32'd0, v);
    check("claim_before_bad", v, 32'd3);
    bus(1'b1, 5'h0C, 32'd0, v);
    bus(1'b1, 5'h0C, 32'd7, v);
    bus(1'b0, 5'h10, 32'd0, v);
    check("insvc_kept", v, 32'h4);
    bus(1'b1, 5'h0C, 32'd3, v);

    // Unmapped address
    bus(1'b1, 5'h1C, 32'hFFFF_FFFF, v);
    bus(1'b0, 5'h1C, 32'd0, v);
    check("unmapped_ack", 32'(ack), 32'd1);
    check("unmapped_rdata", v, 32'd0);

    // Reset during an access
    irq_r = 3'b010;
    req = 1'b1; we = 1'b0; addr = 5'h04; rst = 1'b1;
    tick();
    req = 1'b0; rst = 1'b0;
    check("rst_no_ack", 32'(ack), 32'd0);
    bus(1'b0, 5'h04, 32'd0, v);
    check("rst_enable", v, 32'd0);
    irq_r = 3'b000;

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      irq_r = N'($urandom);
      rst   = ($urandom_range(0, 299) == 0);
      req   = $urandom_range(0, 1);
      we    = $urandom_range(0, 1);
      addr  = 5'($urandom_range(0, 31));
      wdata = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, N + 2)) : $urandom;
      tick();
    end
    rst = 1'b0; req = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
